// File: rtl/aximm_csr_avmm_responder_if.sv
// Host-side AVMM strobe bus between the host register master and the CSR responder.
// Directions are named from the responder's point of view.
interface aximm_csr_avmm_responder_if;
    logic [31:0] i_wr_addr;
    logic [31:0] i_wrdata;
    logic        i_wren;
    logic        i_rden;
    logic [31:0] o_master_readdata;
    logic        o_master_readdatavalid;
    logic        o_master_waitrequest;

    modport slave (
        input  i_wr_addr,
        input  i_wrdata,
        input  i_wren,
        input  i_rden,
        output o_master_readdata,
        output o_master_readdatavalid,
        output o_master_waitrequest
    );

    modport master (
        output i_wr_addr,
        output i_wrdata,
        output i_wren,
        output i_rden,
        input  o_master_readdata,
        input  o_master_readdatavalid,
        input  o_master_waitrequest
    );
endinterface

// File: rtl/aximm_csr_avmm_responder.sv
// CSR responder for the AXI-MM GPIO test harness: edge-detected AVMM strobes, config/delay
// registers, sticky done status and coherent 128-bit capture reads through a shared snapshot.
module aximm_csr_avmm_responder #(
    parameter logic [31:0] DLY_X_RST  = 32'h0000_000C,
    parameter logic [31:0] DLY_Y_RST  = 32'h0000_0020,
    parameter logic [31:0] DLY_Z_RST  = 32'h0000_1770,
    parameter int          RD_LATENCY = 2
) (
    input  logic                               avmm_clk,
    input  logic                               avmm_rst,
    aximm_csr_avmm_responder_if.slave          avmm,
    output logic [31:0]                        o_wr_cfg,
    output logic [31:0]                        o_rd_cfg,
    output logic [31:0]                        o_mm_addr,
    output logic                               o_wr_go,
    output logic                               o_rd_go,
    output logic [31:0]                        o_dly_x,
    output logic [31:0]                        o_dly_y,
    output logic [31:0]                        o_dly_z,
    input  logic [3:0]                         i_linkup,
    input  logic [3:0]                         i_chk_sts,
    input  logic                               i_wr_done,
    input  logic                               i_rd_done,
    input  logic [127:0]                       i_dout_first,
    input  logic [127:0]                       i_dout_last,
    input  logic [127:0]                       i_din_first,
    input  logic [127:0]                       i_din_last
);

    localparam logic [31:0] A_WR_CFG   = 32'h5000_1000;
    localparam logic [31:0] A_MM_ADDR  = 32'h5000_1004;
    localparam logic [31:0] A_BUS_STS  = 32'h5000_1008;
    localparam logic [31:0] A_LINK_STS = 32'h5000_100C;
    localparam logic [31:0] A_RD_CFG   = 32'h5000_1010;
    localparam logic [31:0] A_DLY_X    = 32'h5000_2000;
    localparam logic [31:0] A_DLY_Y    = 32'h5000_2004;
    localparam logic [31:0] A_DLY_Z    = 32'h5000_2008;
    // 0x5000_4000..0x5000_403F holds the four 128-bit capture windows.
    localparam logic [25:0] WIN_BASE   = 26'h140_0100;
    localparam int          WAIT_CYC   = (RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0;
    localparam logic [1:0]  WAIT_INIT  = 2'(WAIT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } rd_state_t;

    rd_state_t      rd_state_r;
    logic [1:0]     rd_cnt_r;
    logic [31:0]    rd_hold_r;
    logic [31:0]    readdata_r;
    logic           readdatavalid_r;
    logic           waitreq_r;
    logic           wren_q_r;
    logic           rden_q_r;
    logic [31:0]    wr_cfg_r;
    logic [31:0]    rd_cfg_r;
    logic [31:0]    mm_addr_r;
    logic [31:0]    dly_x_r;
    logic [31:0]    dly_y_r;
    logic [31:0]    dly_z_r;
    logic           wr_go_r;
    logic           rd_go_r;
    logic           wr_stk_r;
    logic           rd_stk_r;
    logic [127:0]   snap_r;

    logic           wr_edge_s;
    logic           rd_accept_s;
    logic           wr_cfg_hit_s;
    logic           rd_cfg_hit_s;
    logic           win_hit_s;
    logic [1:0]     win_word_s;
    logic [127:0]   win_data_s;
    logic [31:0]    rd_data_s;

    // Request qualification: rising edges only; a write edge wins over a coincident read edge.
    always_comb begin
        wr_edge_s    = avmm.i_wren & ~wren_q_r;
        rd_accept_s  = avmm.i_rden & ~rden_q_r & ~wr_edge_s & ~waitreq_r;
        wr_cfg_hit_s = wr_edge_s & (avmm.i_wr_addr == A_WR_CFG);
        rd_cfg_hit_s = wr_edge_s & (avmm.i_wr_addr == A_RD_CFG);
        win_hit_s    = (avmm.i_wr_addr[31:6] == WIN_BASE) & (avmm.i_wr_addr[1:0] == 2'b00);
        win_word_s   = avmm.i_wr_addr[3:2];
    end

    // Read data mux: word 0 of a window reads live input, words 1..3 read the snapshot.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (avmm.i_wr_addr[5:4])
            2'd0:    win_data_s = i_dout_first;
            2'd1:    win_data_s = i_dout_last;
            2'd2:    win_data_s = i_din_first;
            default: win_data_s = i_din_last;
        endcase
        if (win_hit_s) begin
            case (win_word_s)
                2'd0:    rd_data_s = win_data_s[31:0];
                2'd1:    rd_data_s = snap_r[63:32];
                2'd2:    rd_data_s = snap_r[95:64];
                default: rd_data_s = snap_r[127:96];
            endcase
        end else begin
            case (avmm.i_wr_addr)
                A_WR_CFG:   rd_data_s = wr_cfg_r;
                A_MM_ADDR:  rd_data_s = mm_addr_r;
                A_BUS_STS:  rd_data_s = {26'd0, rd_stk_r, wr_stk_r, i_chk_sts};
                A_LINK_STS: rd_data_s = {28'd0, i_linkup};
                A_RD_CFG:   rd_data_s = rd_cfg_r;
                A_DLY_X:    rd_data_s = dly_x_r;
                A_DLY_Y:    rd_data_s = dly_y_r;
                A_DLY_Z:    rd_data_s = dly_z_r;
                default:    rd_data_s = 32'h0000_0000;
            endcase
        end
    end

    // Strobe history, register writes, go pulses, sticky done bits and capture snapshot.
    always_ff @(posedge avmm_clk) begin
        if (avmm_rst) begin
            wren_q_r  <= 1'b0;
            rden_q_r  <= 1'b0;
            wr_cfg_r  <= 32'h0000_0000;
            rd_cfg_r  <= 32'h0000_0000;
            mm_addr_r <= 32'h0000_0000;
            dly_x_r   <= DLY_X_RST;
            dly_y_r   <= DLY_Y_RST;
            dly_z_r   <= DLY_Z_RST;
            wr_go_r   <= 1'b0;
            rd_go_r   <= 1'b0;
            wr_stk_r  <= 1'b0;
            rd_stk_r  <= 1'b0;
            snap_r    <= 128'd0;
        end else begin
            wren_q_r <= avmm.i_wren;
            rden_q_r <= avmm.i_rden;
            wr_go_r  <= wr_cfg_hit_s;
            rd_go_r  <= rd_cfg_hit_s;
            if (wr_edge_s) begin
                case (avmm.i_wr_addr)
                    A_WR_CFG:  wr_cfg_r  <= avmm.i_wrdata;
                    A_MM_ADDR: mm_addr_r <= avmm.i_wrdata;
                    A_RD_CFG:  rd_cfg_r  <= avmm.i_wrdata;
                    A_DLY_X:   dly_x_r   <= avmm.i_wrdata;
                    A_DLY_Y:   dly_y_r   <= avmm.i_wrdata;
                    A_DLY_Z:   dly_z_r   <= avmm.i_wrdata;
                    default:   wr_cfg_r  <= wr_cfg_r;
                endcase
            end
            // Set has priority over the clear from a config write in the same cycle.
            wr_stk_r <= i_wr_done | (wr_stk_r & ~wr_cfg_hit_s);
            rd_stk_r <= i_rd_done | (rd_stk_r & ~rd_cfg_hit_s);
            if (rd_accept_s && win_hit_s && (win_word_s == 2'd0)) begin
                snap_r <= win_data_s;
            end
        end
    end

    // Read FSM: holds the data sampled at acceptance and releases it after RD_LATENCY cycles.
    always_ff @(posedge avmm_clk) begin
        if (avmm_rst) begin
            rd_state_r      <= ST_IDLE;
            rd_cnt_r        <= 2'd0;
            rd_hold_r       <= 32'h0000_0000;
            readdata_r      <= 32'h0000_0000;
            readdatavalid_r <= 1'b0;
            waitreq_r       <= 1'b0;
        end else begin
            readdatavalid_r <= 1'b0;
            case (rd_state_r)
                ST_IDLE, ST_VALID: begin
                    if (rd_accept_s) begin
                        rd_hold_r <= rd_data_s;
                        if (RD_LATENCY == 1) begin
                            readdata_r      <= rd_data_s;
                            readdatavalid_r <= 1'b1;
                            rd_state_r      <= ST_VALID;
                        end else begin
                            waitreq_r  <= 1'b1;
                            rd_cnt_r   <= WAIT_INIT;
                            rd_state_r <= ST_WAIT;
                        end
                    end else begin
                        rd_state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (rd_cnt_r == 2'd0) begin
                        readdata_r      <= rd_hold_r;
                        readdatavalid_r <= 1'b1;
                        waitreq_r       <= 1'b0;
                        rd_state_r      <= ST_VALID;
                    end else begin
                        rd_cnt_r <= rd_cnt_r - 2'd1;
                    end
                end
                default: begin
                    waitreq_r  <= 1'b0;
                    rd_state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign avmm.o_master_readdata      = readdata_r;
    assign avmm.o_master_readdatavalid = readdatavalid_r;
    assign avmm.o_master_waitrequest   = waitreq_r;
    assign o_wr_cfg  = wr_cfg_r;
    assign o_rd_cfg  = rd_cfg_r;
    assign o_mm_addr = mm_addr_r;
    assign o_wr_go   = wr_go_r;
    assign o_rd_go   = rd_go_r;
    assign o_dly_x   = dly_x_r;
    assign o_dly_y   = dly_y_r;
    assign o_dly_z   = dly_z_r;

endmodule

// File: tb/tb_aximm_csr_avmm_responder.sv
// Directed plus randomized bench for the CSR responder, checked against a register-map model
// that tracks RW contents, sticky bits and the capture snapshot as plain variables.
module tb_aximm_csr_avmm_responder;
    localparam int          LAT        = 2;
    localparam logic [31:0] A_WR_CFG   = 32'h5000_1000;
    localparam logic [31:0] A_MM_ADDR  = 32'h5000_1004;
    localparam logic [31:0] A_BUS_STS  = 32'h5000_1008;
    localparam logic [31:0] A_LINK_STS = 32'h5000_100C;
    localparam logic [31:0] A_RD_CFG   = 32'h5000_1010;
    localparam logic [31:0] A_DLY_X    = 32'h5000_2000;
    localparam logic [31:0] A_DLY_Y    = 32'h5000_2004;
    localparam logic [31:0] A_DLY_Z    = 32'h5000_2008;
    localparam logic [31:0] A_WIN      = 32'h5000_4000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    o_wr_cfg, o_rd_cfg, o_mm_addr, o_dly_x, o_dly_y, o_dly_z;
    logic           o_wr_go, o_rd_go;
    logic [3:0]     linkup = 4'h0;
    logic [3:0]     chk_sts = 4'h0;
    logic           wr_done = 1'b0;
    logic           rd_done = 1'b0;
    logic [127:0]   dout_first = 128'd0, dout_last = 128'd0, din_first = 128'd0, din_last = 128'd0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]    m_wr_cfg, m_rd_cfg, m_mm_addr, m_dx, m_dy, m_dz;
    logic           m_wstk, m_rstk;
    logic [127:0]   m_snap;
    logic [31:0]    alist [0:10];

    aximm_csr_avmm_responder_if bus ();

    aximm_csr_avmm_responder #(
        .DLY_X_RST  (32'h0000_000C),
        .DLY_Y_RST  (32'h0000_0020),
        .DLY_Z_RST  (32'h0000_1770),
        .RD_LATENCY (LAT)
    ) dut (
        .avmm_clk     (clk),
        .avmm_rst     (rst),
        .avmm         (bus.slave),
        .o_wr_cfg     (o_wr_cfg),
        .o_rd_cfg     (o_rd_cfg),
        .o_mm_addr    (o_mm_addr),
        .o_wr_go      (o_wr_go),
        .o_rd_go      (o_rd_go),
        .o_dly_x      (o_dly_x),
        .o_dly_y      (o_dly_y),
        .o_dly_z      (o_dly_z),
        .i_linkup     (linkup),
        .i_chk_sts    (chk_sts),
        .i_wr_done    (wr_done),
        .i_rd_done    (rd_done),
        .i_dout_first (dout_first),
        .i_dout_last  (dout_last),
        .i_din_first  (din_first),
        .i_din_last   (din_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr_cfg = 32'd0; m_rd_cfg = 32'd0; m_mm_addr = 32'd0;
        m_dx = 32'h0000_000C; m_dy = 32'h0000_0020; m_dz = 32'h0000_1770;
        m_wstk = 1'b0; m_rstk = 1'b0; m_snap = 128'd0;
    endtask

    // Expected read value at acceptance, with the word-0 snapshot side effect.
    task automatic model_read(input logic [31:0] a, output logic [31:0] r);
        logic [31:0]  off;
        logic [127:0] win;
        int           w;
        off = a - A_WIN;
        case (a)
            A_WR_CFG:   r = m_wr_cfg;
            A_MM_ADDR:  r = m_mm_addr;
            A_BUS_STS:  r = {26'd0, m_rstk, m_wstk, chk_sts};
            A_LINK_STS: r = {28'd0, linkup};
            A_RD_CFG:   r = m_rd_cfg;
            A_DLY_X:    r = m_dx;
            A_DLY_Y:    r = m_dy;
            A_DLY_Z:    r = m_dz;
            default: begin
                r = 32'd0;
                if (a >= A_WIN && off < 32'd64 && off % 32'd4 == 32'd0) begin
                    case (off / 32'd16)
                        32'd0:   win = dout_first;
                        32'd1:   win = dout_last;
                        32'd2:   win = din_first;
                        default: win = din_last;
                    endcase
                    w = int'((off % 32'd16) / 32'd4);
                    if (w == 0) begin
                        m_snap = win;
                        r = win[31:0];
                    end else begin
                        r = m_snap[32*w +: 32];
                    end
                end
            end
        endcase
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_wr_cfg"}, o_wr_cfg, m_wr_cfg);
        check({tag, "_rd_cfg"}, o_rd_cfg, m_rd_cfg);
        check({tag, "_mm_addr"}, o_mm_addr, m_mm_addr);
        check({tag, "_dly_x"}, o_dly_x, m_dx);
        check({tag, "_dly_y"}, o_dly_y, m_dy);
        check({tag, "_dly_z"}, o_dly_z, m_dz);
    endtask

    // Write with wren held for hold cycles; done = {rd_done, wr_done} pulsed in the acceptance cycle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int hold,
                            input logic [1:0] done, input string tag);
        int gw, gr;
        gw = 0; gr = 0;
        @(negedge clk);
        bus.i_wr_addr = a; bus.i_wrdata = d; bus.i_wren = 1'b1;
        wr_done = done[0]; rd_done = done[1];
        for (int k = 0; k < hold + 2; k++) begin
            @(negedge clk);
            wr_done = 1'b0; rd_done = 1'b0;
            if (k == hold - 1) bus.i_wren = 1'b0;
            gw += int'(o_wr_go);
            gr += int'(o_rd_go);
        end
        case (a)
            A_WR_CFG:  m_wr_cfg = d;
            A_MM_ADDR: m_mm_addr = d;
            A_RD_CFG:  m_rd_cfg = d;
            A_DLY_X:   m_dx = d;
            A_DLY_Y:   m_dy = d;
            A_DLY_Z:   m_dz = d;
            default:   ;
        endcase
        m_wstk = done[0] | (m_wstk & (a != A_WR_CFG));
        m_rstk = done[1] | (m_rstk & (a != A_RD_CFG));
        check({tag, "_wr_go_cnt"}, 32'(gw), (a == A_WR_CFG) ? 32'd1 : 32'd0);
        check({tag, "_rd_go_cnt"}, 32'(gr), (a == A_RD_CFG) ? 32'd1 : 32'd0);
        check_regs(tag);
    endtask

    // Single read pulse: waitrequest for LAT-1 cycles, then one valid cycle, then data held.
    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        bus.i_wr_addr = a; bus.i_rden = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            bus.i_rden = 1'b0;
            if (k < LAT) begin
                check({tag, "_wait"}, {30'd0, bus.o_master_readdatavalid, bus.o_master_waitrequest}, 32'd1);
            end else begin
                check({tag, "_valid"}, {30'd0, bus.o_master_readdatavalid, bus.o_master_waitrequest}, 32'd2);
                check({tag, "_data"}, bus.o_master_readdata, exp);
            end
        end
        @(negedge clk);
        check({tag, "_after"}, {31'd0, bus.o_master_readdatavalid}, 32'd0);
        check({tag, "_hold"}, bus.o_master_readdata, exp);
    endtask

    task automatic rand_inputs();
        dout_first = {$urandom(), $urandom(), $urandom(), $urandom()};
        dout_last  = {$urandom(), $urandom(), $urandom(), $urandom()};
        din_first  = {$urandom(), $urandom(), $urandom(), $urandom()};
        din_last   = {$urandom(), $urandom(), $urandom(), $urandom()};
        linkup     = 4'($urandom());
        chk_sts    = 4'($urandom());
    endtask

    initial begin
        logic [31:0] e, a, d;
        int vcnt;
        alist[0] = A_WR_CFG;  alist[1] = A_MM_ADDR; alist[2] = A_BUS_STS; alist[3] = A_LINK_STS;
        alist[4] = A_RD_CFG;  alist[5] = A_DLY_X;   alist[6] = A_DLY_Y;   alist[7] = A_DLY_Z;
        alist[8] = 32'h5000_3000; alist[9] = 32'h5000_1001; alist[10] = 32'h4000_1000;
        bus.i_wr_addr = 32'd0; bus.i_wrdata = 32'd0; bus.i_wren = 1'b0; bus.i_rden = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_readdata", bus.o_master_readdata, 32'd0);
        check("rst_valid_wait", {30'd0, bus.o_master_readdatavalid, bus.o_master_waitrequest}, 32'd0);
        check("rst_go", {30'd0, o_wr_go, o_rd_go}, 32'd0);
        check_regs("rst");
        rst = 1'b0;

        do_read(A_DLY_Z, 32'h0000_1770, "rd_dlyz");
        do_read(A_WR_CFG, 32'h0000_0000, "rd_wrcfg0");
        do_write(A_WR_CFG, 32'h0004_1804, 3, 2'b00, "wr_cfg_held");
        check("wr_cfg_val", o_wr_cfg, 32'h0004_1804);

        chk_sts = 4'hF;
        @(negedge clk); wr_done = 1'b1;
        @(negedge clk); wr_done = 1'b0; m_wstk = 1'b1;
        do_read(A_BUS_STS, 32'h0000_001F, "sts_wdone");
        do_write(A_WR_CFG, 32'h0000_0011, 1, 2'b00, "wr_cfg_clr");
        do_read(A_BUS_STS, 32'h0000_000F, "sts_cleared");
        do_write(A_WR_CFG, 32'h0000_0022, 1, 2'b01, "wr_cfg_setwins");
        do_read(A_BUS_STS, 32'h0000_001F, "sts_setwins");
        @(negedge clk); rd_done = 1'b1;
        @(negedge clk); rd_done = 1'b0; m_rstk = 1'b1;
        do_read(A_BUS_STS, 32'h0000_003F, "sts_rdone");
        do_write(A_RD_CFG, 32'hA5A5_0001, 2, 2'b00, "rd_cfg_clr");
        do_read(A_BUS_STS, 32'h0000_001F, "sts_rclr");
        linkup = 4'hA;
        do_read(A_LINK_STS, 32'h0000_000A, "linkup");

        dout_first = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        model_read(A_WIN, e);
        do_read(A_WIN, 32'h0302_0100, "snap_w0");
        dout_first = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_read(A_WIN + 32'd4, e);
        do_read(A_WIN + 32'd4, 32'h0706_0504, "snap_w1");
        dout_first = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_read(A_WIN + 32'd8, e);
        do_read(A_WIN + 32'd8, 32'h0B0A_0908, "snap_w2");
        dout_first = ~dout_first;
        model_read(A_WIN + 32'd12, e);
        do_read(A_WIN + 32'd12, 32'h0F0E_0D0C, "snap_w3");

        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            if ($urandom_range(0, 3) == 0) begin
                a = alist[$urandom_range(0, 10)];
                d = $urandom();
                do_write(a, d, int'($urandom_range(1, 3)), 2'b00, "rnd_wr");
            end else begin
                if ($urandom_range(0, 1) == 0) a = alist[$urandom_range(0, 10)];
                else a = A_WIN + 32'(4 * $urandom_range(0, 15));
                model_read(a, e);
                do_read(a, e, "rnd_rd");
            end
        end

        d = $urandom();
        vcnt = 0;
        @(negedge clk);
        bus.i_wr_addr = A_DLY_X; bus.i_wrdata = d; bus.i_wren = 1'b1; bus.i_rden = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            bus.i_wren = 1'b0; bus.i_rden = 1'b0;
            vcnt += int'(bus.o_master_readdatavalid);
        end
        m_dx = d;
        check("both_edges_no_valid", 32'(vcnt), 32'd0);
        check("both_edges_write", o_dly_x, d);
        do_read(32'h5000_3000, 32'h0000_0000, "unmapped");

        do_write(A_DLY_Y, 32'h1234_5678, 1, 2'b00, "pre_rst_dly");
        @(negedge clk);
        bus.i_wr_addr = A_DLY_Y; bus.i_rden = 1'b1;
        @(negedge clk);
        bus.i_rden = 1'b0;
        check("mid_rd_wait", {31'd0, bus.o_master_waitrequest}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid_wait", {30'd0, bus.o_master_readdatavalid, bus.o_master_waitrequest}, 32'd0);
        rst = 1'b0;
        model_reset();
        vcnt = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            vcnt += int'(bus.o_master_readdatavalid);
        end
        check("mid_rst_no_valid", 32'(vcnt), 32'd0);
        check("mid_rst_readdata", bus.o_master_readdata, 32'd0);
        check_regs("post_rst");
        do_read(A_DLY_Y, 32'h0000_0020, "post_rst_rd");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
